// File: rtl/ascon_dec_fsm.sv
// ascon_dec_fsm: ASCON-128 decryption sequencer (init, one AD block, N_BLOCKS ciphertext blocks, tag check)
//   clock_i/reset_i                : clock, asynchronous active-high reset
//   start_i, cipher_text_i, tag_i, da_i : request and message, captured at an accepted start
//   core_*_o                       : registered strobes/data to the ASCON core
//   core_*_i                       : completion events, recovered plaintext and computed tag from the core
//   plain_text_o, busy_o, done_o, tag_ok_o : result interface
//   ASCON_DEC_PLAIN_GATE_EN        : when defined, plaintext is only released after a matching tag
module ascon_dec_fsm #(
  parameter int N_BLOCKS = 23,
  parameter int CNT_W = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [N_BLOCKS*64-1:0] cipher_text_i,
  input  logic [127:0]          tag_i,
  input  logic [63:0]           da_i,
  output logic                  core_init_o,
  output logic                  core_associate_data_o,
  output logic                  core_finalisation_o,
  output logic                  core_decrypt_o,
  output logic [63:0]           core_data_o,
  output logic                  core_data_valid_o,
  input  logic                  core_end_initialisation_i,
  input  logic                  core_end_associate_i,
  input  logic                  core_plain_valid_i,
  input  logic [63:0]           core_plain_i,
  input  logic                  core_end_tag_i,
  input  logic [127:0]          core_tag_i,
  output logic [N_BLOCKS*64-1:0] plain_text_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tag_ok_o
);
  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_INIT, AD, WAIT_AD, BLK_SEND, BLK_WAIT, BLK_NEXT, FINAL, WAIT_TAG, DONE
  } state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [0:N_BLOCKS-1][63:0] ct_q, pt_q;
  logic [127:0] tag_q;
  logic [63:0] ad_q, blk_nx;
  logic last;
  assign cnt_nx = cnt + 1'b1;
  assign last = cnt_nx == CNT_W'(N_BLOCKS - 1);
  always_comb begin
    blk_nx = '0;
    for (int i = 0; i < N_BLOCKS; i++) blk_nx = (cnt_nx == CNT_W'(i)) ? ct_q[i] : blk_nx;
  end
`ifdef ASCON_DEC_PLAIN_GATE_EN
  logic rel_q;
  assign plain_text_o = rel_q ? pt_q : '0;
`else
  assign plain_text_o = pt_q;
`endif
  // Outputs are set on the transition into the state they belong to, so every strobe is a flop.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      ct_q <= '0;
      pt_q <= '0;
      tag_q <= '0;
      ad_q <= '0;
      core_init_o <= 1'b0;
      core_associate_data_o <= 1'b0;
      core_finalisation_o <= 1'b0;
      core_decrypt_o <= 1'b0;
      core_data_o <= '0;
      core_data_valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      tag_ok_o <= 1'b0;
`ifdef ASCON_DEC_PLAIN_GATE_EN
      rel_q <= 1'b0;
`endif
    end else begin
      core_init_o <= 1'b0;
      core_associate_data_o <= 1'b0;
      core_finalisation_o <= 1'b0;
      core_data_o <= '0;
      core_data_valid_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          ct_q <= cipher_text_i;
          tag_q <= tag_i;
          ad_q <= da_i;
          pt_q <= '0;
          tag_ok_o <= 1'b0;
`ifdef ASCON_DEC_PLAIN_GATE_EN
          rel_q <= 1'b0;
`endif
          cnt <= '0;
          busy_o <= 1'b1;
          core_decrypt_o <= 1'b1;
          core_init_o <= 1'b1;
          state <= INIT;
        end
        INIT: state <= WAIT_INIT;
        WAIT_INIT: if (core_end_initialisation_i) begin
          core_init_o <= 1'b1;
          core_associate_data_o <= 1'b1;
          core_data_o <= ad_q;
          core_data_valid_o <= 1'b1;
          state <= AD;
        end
        AD: state <= WAIT_AD;
        WAIT_AD: if (core_end_associate_i) begin
          core_data_o <= ct_q[0];
          core_data_valid_o <= 1'b1;
          core_finalisation_o <= N_BLOCKS == 1;
          state <= (N_BLOCKS == 1) ? FINAL : BLK_SEND;
        end
        BLK_SEND: state <= BLK_WAIT;
        BLK_WAIT: if (core_plain_valid_i) begin
          for (int i = 0; i < N_BLOCKS; i++) if (cnt == CNT_W'(i)) pt_q[i] <= core_plain_i;
          state <= BLK_NEXT;
        end
        BLK_NEXT: begin
          cnt <= cnt_nx;
          core_data_o <= blk_nx;
          core_data_valid_o <= 1'b1;
          core_finalisation_o <= last;
          state <= last ? FINAL : BLK_SEND;
        end
        FINAL: state <= WAIT_TAG;
        // Plaintext and tag may land in the same cycle; both are taken.
        WAIT_TAG: begin
          if (core_plain_valid_i) pt_q[N_BLOCKS-1] <= core_plain_i;
          if (core_end_tag_i) begin
            tag_ok_o <= core_tag_i == tag_q;
`ifdef ASCON_DEC_PLAIN_GATE_EN
            rel_q <= core_tag_i == tag_q;
`endif
            done_o <= 1'b1;
            core_decrypt_o <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_dec_fsm.sv
// tb_ascon_dec_fsm: directed bench for ascon_dec_fsm with a behavioural ASCON core stand-in
module tb_ascon_dec_fsm;
  localparam int N = 23;
  localparam logic [63:0] K = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [127:0] MT = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [63:0] AD_V = 64'hAD00_0000_0000_AD01;
  logic clock_i = 1'b0, reset_i = 1'b1;
  always #5 clock_i = ~clock_i;
  logic start_i = 1'b0;
  logic [N*64-1:0] cipher_text_i = '0, plain_text_o;
  logic [127:0] tag_i = '0, core_tag_i;
  logic [63:0] da_i = '0, core_data_o, core_plain_i = '0;
  logic core_init_o, core_associate_data_o, core_finalisation_o, core_decrypt_o, core_data_valid_o;
  logic core_end_initialisation_i = 1'b0, core_end_associate_i = 1'b0, core_plain_valid_i = 1'b0, core_end_tag_i = 1'b0;
  logic busy_o, done_o, tag_ok_o;
  logic s_start = 1'b0;
  logic [63:0] s_ct = '0, s_pt, s_data, s_plain = '0;
  logic [127:0] s_tag = '0;
  logic s_init, s_ad, s_fin, s_dec, s_valid, s_busy, s_done, s_ok;
  logic s_ei = 1'b0, s_ea = 1'b0, s_pv = 1'b0, s_et = 1'b0;
  assign core_tag_i = MT;
  ascon_dec_fsm #(.N_BLOCKS(N), .CNT_W(5)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .cipher_text_i(cipher_text_i),
    .tag_i(tag_i), .da_i(da_i), .core_init_o(core_init_o), .core_associate_data_o(core_associate_data_o),
    .core_finalisation_o(core_finalisation_o), .core_decrypt_o(core_decrypt_o), .core_data_o(core_data_o),
    .core_data_valid_o(core_data_valid_o), .core_end_initialisation_i(core_end_initialisation_i),
    .core_end_associate_i(core_end_associate_i), .core_plain_valid_i(core_plain_valid_i),
    .core_plain_i(core_plain_i), .core_end_tag_i(core_end_tag_i), .core_tag_i(core_tag_i),
    .plain_text_o(plain_text_o), .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o));
  ascon_dec_fsm #(.N_BLOCKS(1), .CNT_W(5)) dut1 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(s_start), .cipher_text_i(s_ct),
    .tag_i(s_tag), .da_i(AD_V), .core_init_o(s_init), .core_associate_data_o(s_ad),
    .core_finalisation_o(s_fin), .core_decrypt_o(s_dec), .core_data_o(s_data),
    .core_data_valid_o(s_valid), .core_end_initialisation_i(s_ei),
    .core_end_associate_i(s_ea), .core_plain_valid_i(s_pv),
    .core_plain_i(s_plain), .core_end_tag_i(s_et), .core_tag_i(MT),
    .plain_text_o(s_pt), .busy_o(s_busy), .done_o(s_done), .tag_ok_o(s_ok));
  // Core stand-in: every request is answered two cycles later; a final block returns plaintext and tag together.
  logic [1:0] ei_p, ea_p, pv_p, et_p, s_ei_p, s_ea_p, s_pv_p, s_et_p;
  logic [63:0] d0, d1, s_d0, s_d1;
  always @(negedge clock_i) begin
    if (reset_i) begin
      {ei_p, ea_p, pv_p, et_p, s_ei_p, s_ea_p, s_pv_p, s_et_p} = '0;
      {core_end_initialisation_i, core_end_associate_i, core_plain_valid_i, core_end_tag_i} = '0;
      {s_ei, s_ea, s_pv, s_et} = '0;
    end else begin
      core_end_initialisation_i = ei_p[1];
      core_end_associate_i = ea_p[1];
      core_plain_valid_i = pv_p[1];
      core_end_tag_i = et_p[1];
      core_plain_i = d1;
      ei_p = {ei_p[0], core_init_o & ~core_associate_data_o};
      ea_p = {ea_p[0], core_associate_data_o & core_data_valid_o};
      pv_p = {pv_p[0], core_data_valid_o & ~core_associate_data_o};
      et_p = {et_p[0], core_data_valid_o & core_finalisation_o};
      d1 = d0;
      d0 = core_data_o ^ K;
      s_ei = s_ei_p[1];
      s_ea = s_ea_p[1];
      s_pv = s_pv_p[1];
      s_et = s_et_p[1];
      s_plain = s_d1;
      s_ei_p = {s_ei_p[0], s_init & ~s_ad};
      s_ea_p = {s_ea_p[0], s_ad & s_valid};
      s_pv_p = {s_pv_p[0], s_valid & ~s_ad};
      s_et_p = {s_et_p[0], s_valid & s_fin};
      s_d1 = s_d0;
      s_d0 = s_data ^ K;
    end
  end
  int n_cmp = 0, n_err = 0;
  int dp, fp, fv, dn, post, k, st;
  logic got, okd;
  logic [63:0] adv;
  logic [N*64-1:0] pt_d, ct_good, ct_bad;
  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  function automatic logic [N*64-1:0] mk(input logic [63:0] base);
    logic [N*64-1:0] r;
    for (int i = 0; i < N; i++) r[(N-i)*64-1 -: 64] = base + 64'(i);
    return r;
  endfunction
  task automatic chk_plain(input string t, input logic [N*64-1:0] v, input bit z);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_%0d", t, i), {64'h0, v[(N-i)*64-1 -: 64]}, z ? 128'h0 : {64'h0, (64'h1000 + 64'(i)) ^ K});
  endtask
  task automatic pulse_start();
    @(negedge clock_i) start_i = 1'b1;
    @(negedge clock_i) start_i = 1'b0;
  endtask
  task automatic run_msg();
    dp = 0; fp = 0; fv = 0; dn = 0; post = 0; got = 1'b0; okd = 1'b0; adv = '0; pt_d = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock_i);
      if (core_data_valid_o && !core_associate_data_o) begin
        dp++;
        if (core_finalisation_o) fv++;
      end
      if (core_finalisation_o) fp++;
      if (core_associate_data_o && core_data_valid_o) adv = core_data_o;
      if (done_o) begin
        dn++;
        if (!got) begin
          okd = tag_ok_o;
          pt_d = plain_text_o;
        end
        got = 1'b1;
      end
      if (got) post++;
      if (post > 4) break;
    end
    chk("done_seen", got, 1);
    chk("done_once", dn, 1);
  endtask
  task automatic wait_blocks(input int n);
    k = 0;
    for (int c = 0; c < 1000 && k < n; c++) begin
      @(negedge clock_i);
      if (core_data_valid_o && !core_associate_data_o) k++;
    end
    chk("blk_reached", k, n);
  endtask
  initial begin
    ct_good = mk(64'h1000);
    ct_bad = mk(64'hDEAD_0000_0000_0000);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tag_ok", tag_ok_o, 0);
    chk("rst_strobes", {core_init_o, core_associate_data_o, core_finalisation_o, core_decrypt_o, core_data_valid_o}, 0);
    chk("rst_data", core_data_o, 0);
    chk("rst_plain", |plain_text_o, 0);
    st = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock_i);
      if (core_init_o | core_associate_data_o | core_finalisation_o | core_data_valid_o | core_decrypt_o | busy_o | done_o) st++;
    end
    chk("idle_activity", st, 0);
    cipher_text_i = ct_good; tag_i = MT; da_i = AD_V;
    pulse_start();
    run_msg();
    chk("m1_tag_ok", okd, 1);
    chk("m1_data_pulses", dp, N);
    chk("m1_nonfinal", dp - fv, N - 1);
    chk("m1_fin_pulses", fp, 1);
    chk("m1_fin_valid", fv, 1);
    chk("m1_ad_data", adv, AD_V);
    chk_plain("m1_plain", pt_d, 0);
    chk("m1_busy_after", busy_o, 0);
    chk("m1_tag_ok_held", tag_ok_o, 1);
    tag_i = MT ^ 128'h1;
    pulse_start();
    run_msg();
    chk("m2_tag_ok", okd, 0);
    chk("m2_tag_ok_held", tag_ok_o, 0);
`ifdef ASCON_DEC_PLAIN_GATE_EN
    chk_plain("m2_plain", plain_text_o, 1);
`else
    chk_plain("m2_plain", plain_text_o, 0);
`endif
    tag_i = MT;
    pulse_start();
    wait_blocks(6);
    @(negedge clock_i);
    start_i = 1'b1; cipher_text_i = ct_bad; tag_i = '0; da_i = '0;
    @(negedge clock_i) start_i = 1'b0;
    run_msg();
    chk("m3_tag_ok", okd, 1);
    chk("m3_rest_pulses", dp, N - 6);
    chk_plain("m3_plain", pt_d, 0);
    cipher_text_i = ct_good; tag_i = MT; da_i = AD_V;
    pulse_start();
    wait_blocks(11);
    reset_i = 1'b1;
    #1;
    chk("m4_rst_busy", busy_o, 0);
    chk("m4_rst_strobes", {core_init_o, core_associate_data_o, core_finalisation_o, core_decrypt_o, core_data_valid_o, done_o}, 0);
    chk("m4_rst_data", core_data_o, 0);
    chk("m4_rst_plain", |plain_text_o, 0);
    st = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_i);
      if (c == 3) reset_i = 1'b0;
      if (core_init_o | core_data_valid_o | core_decrypt_o | busy_o | done_o) st++;
    end
    chk("m4_idle_after", st, 0);
    pulse_start();
    run_msg();
    chk("m4_tag_ok", okd, 1);
    chk("m4_data_pulses", dp, N);
    chk_plain("m4_plain", pt_d, 0);
    s_ct = 64'h2000; s_tag = MT;
    @(negedge clock_i) s_start = 1'b1;
    @(negedge clock_i) s_start = 1'b0;
    dp = 0; fv = 0; dn = 0; got = 1'b0; okd = 1'b0;
    begin
      int ti, ta, td, cyc;
      ti = -1; ta = -1; td = -1; cyc = 1;
      if (s_init && !s_ad) ti = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clock_i);
        if (s_init && !s_ad && ti < 0) ti = cyc;
        if (s_ad && s_valid && ta < 0) ta = cyc;
        if (s_valid && !s_ad) begin
          dp++;
          if (td < 0) td = cyc;
          if (s_fin) fv++;
        end
        if (s_done) begin
          dn++;
          okd = s_ok;
          got = 1'b1;
        end
        cyc++;
      end
      chk("n1_done", got, 1);
      chk("n1_order", (ti >= 0) && (ta > ti) && (td > ta), 1);
    end
    chk("n1_data_pulses", dp, 1);
    chk("n1_fin_valid", fv, 1);
    chk("n1_tag_ok", okd, 1);
    chk("n1_plain", s_pt, 64'h2000 ^ K);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
